seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial sequence detector generalising the fixed 4-bit "1011" Moore detector. It matches a runtime-loadable pattern of PAT_LEN bits on a 1-bit serial input with a qualifying enable. Overlapping and non-overlapping detection are selectable per cycle, and a saturating match counter is provided. It sits in the same serial-input datapath as the fixed detector and replaces it where a pattern other than 1011 or a match count is needed.

## Interface
- PAT_LEN, 4: pattern length in bits; legal range 2..32.
- PATTERN, 4'b1011: reset value of the pattern register; PAT_LEN bits; MSB is the first bit received.
- CNT_W, 8: width of match_cnt.

- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high; highest priority.
- en  input  1  sample qualifier; xin is consumed only on edges where en=1.
- xin  input  1  serial data bit.
- load  input  1  pattern load strobe; when 1, pat_in is written to the pattern register.
- pat_in  input  PAT_LEN  new pattern; MSB is the first bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled on each match edge.
- zout  output  1  registered match flag; 1-cycle pulse per match.
- match_cnt  output  CNT_W  number of matches since reset or load; saturates at all-ones.

## Operation
- State registers:
  - pat: PAT_LEN bits.
  - hist: PAT_LEN-1 bits, holding the most recent samples.
  - fill: number of valid samples; saturates at PAT_LEN-1.
  - zout, match_cnt.
- Define cand = {hist, xin}, where xin is the newest bit in the LSB.
- A match occurs on an edge when all of the following hold: en=1, fill == PAT_LEN-1, and cand == pat.
- Edge priority is rst > load > en > idle.
- rst=1:
  - pat <= PATTERN; hist <= 0; fill <= 0; zout <= 0; match_cnt <= 0.
- load=1 (rst=0):
  - pat <= pat_in; hist <= 0; fill <= 0; zout <= 0; match_cnt <= 0.
  - xin and en are ignored on this edge.
- en=1, no match:
  - hist <= cand[PAT_LEN-2:0]; fill <= min(fill+1, PAT_LEN-1); zout <= 0.
- en=1, match:
  - zout <= 1.
  - match_cnt <= match_cnt+1, unless it is already all-ones, in which case it holds.
  - If overlap=1: hist <= cand[PAT_LEN-2:0] and fill stays at PAT_LEN-1, so the match suffix can seed the next match.
  - If overlap=0: hist <= 0 and fill <= 0, so the next match needs PAT_LEN fresh bits.
- en=0 (no rst, no load):
  - hist, fill, pat and match_cnt hold; zout <= 0.
- Effective state machine: fill encodes states S0..S(PAT_LEN-1), with the match state realised by zout.
  - Overlap mode is equivalent to a full-history Moore FSM, including self-overlap; e.g. for 1011 the trailing 1 seeds the next match.
- Output behaviour:
  - zout never stays high for two consecutive cycles unless two consecutive enabled samples both match (overlap mode, e.g. pattern 11 on input 111).
  - Each zout pulse coincides with a match_cnt increment, except when the counter is saturated.

## Timing
- Detection latency: zout rises in the cycle after the edge that samples the last pattern bit, and is high for exactly that one cycle.
- match_cnt updates on the same edge that sets zout.
- load takes effect in one cycle; the first bit of a new pattern is sampled no earlier than the edge after load.
- Reset applied mid-pattern discards partial history, and the next match needs PAT_LEN full bits. Same for load.
- Gaps where en=0 are transparent to matching; bits need not be on consecutive cycles.
- No combinational path from inputs to outputs.

## Test plan
- Reset defaults, PATTERN=1011, overlap=1, en=1:
  - Stream 1,0,1,1,0,1,1 → zout pulses after bit 4 and after bit 7; match_cnt = 2.
- Non-overlap, overlap=0:
  - Stream 1,0,1,1,0,1,1 → one pulse, after bit 4; match_cnt = 1.
  - Stream 1,0,1,1,1,0,1,1 → pulses after bit 4 and bit 8.
- Load and enable gaps:
  - load with pat_in=1101 after 3 bits of a partial 1011 → counter cleared.
  - Then stream 1,1,0,1 with en=0 cycles inserted between bits → exactly one pulse, in the cycle after the enabled edge for the final 1.
- Counter saturation, CNT_W=2, PATTERN=11, overlap=1:
  - Six 1s → five matches; match_cnt sticks at 3 while zout still pulses every cycle from bit 2 onward.
- Reset mid-operation:
  - Assert rst after 1,0,1; release; then send 1 → no match.
  - Then 0,1,1 → match after the 4th bit post-reset; zout=0 and match_cnt=0 during and just after reset.

Source files
------------

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable PAT_LEN-bit pattern, selectable
// overlapping/non-overlapping matching and a saturating match counter.
module seq_detect_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               xin,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               overlap,
  output logic               zout,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int FILL_W = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               zout_q, zout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_LEN-1:0] cand;
  logic               match;

  // The newest bit completes the candidate window; a match needs a full history.
  assign cand  = {hist_q, xin};
  assign match = en && (fill_q == FILL_MAX) && (cand == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    zout_d = 1'b0;
    if (load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (en) begin
      if (match) begin
        zout_d = 1'b1;
        if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
        if (overlap) begin
          hist_d = cand[PAT_LEN-2:0];
        end else begin
          hist_d = '0;
          fill_d = '0;
        end
      end else begin
        hist_d = cand[PAT_LEN-2:0];
        fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      zout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      zout_q <= zout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign zout      = zout_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a default 1011 detector plus a 2-bit
// pattern instance with a 2-bit counter for saturation.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst, load, xin, overlap;
  logic       en1, en2;
  logic [3:0] pat_in1;
  logic [1:0] pat_in2;
  logic       zout1, zout2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .xin(xin), .load(load),
    .pat_in(pat_in1), .overlap(overlap), .zout(zout1), .match_cnt(cnt1)
  );

  seq_detect_param #(.PAT_LEN(2), .PATTERN(2'b11), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .xin(xin), .load(load),
    .pat_in(pat_in2), .overlap(overlap), .zout(zout2), .match_cnt(cnt2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one clock edge worth of inputs, then settle past the edge.
  task automatic applyStimulus(input logic r, input logic l, input logic e1,
                               input logic e2, input logic x);
    rst  = r;
    load = l;
    en1  = e1;
    en2  = e2;
    xin  = x;
    @(posedge clk);
    #1;
  endtask

  // Feed n bits (MSB first) into dut1 and check zout after every edge.
  task automatic runStream(input string tag, input logic [7:0] bits, input int n,
                           input logic [7:0] expZ);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, bits[n-1-i]);
      checkOutput($sformatf("%s_z%0d", tag, i + 1), 32'(zout1), 32'(expZ[n-1-i]));
    end
  endtask

  task automatic resetBoth();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; en1 = 1'b0; en2 = 1'b0; xin = 1'b0;
    overlap = 1'b1; pat_in1 = 4'b0000; pat_in2 = 2'b00;

    resetBoth();
    checkOutput("rst_z1", 32'(zout1), 32'd0);
    checkOutput("rst_c1", 32'(cnt1), 32'd0);
    checkOutput("rst_z2", 32'(zout2), 32'd0);
    checkOutput("rst_c2", 32'(cnt2), 32'd0);

    // Overlapping 1011 detection: the trailing 1 seeds the second match.
    overlap = 1'b1;
    runStream("ovl", 8'b0101_1011, 7, 8'b0000_1001);
    checkOutput("ovl_cnt", 32'(cnt1), 32'd2);

    // Partial history 1,0,1 then reset mid-pattern.
    runStream("pre", 8'b0000_0101, 3, 8'b0000_0000);
    checkOutput("pre_cnt", 32'(cnt1), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("mid_rst_z", 32'(zout1), 32'd0);
    checkOutput("mid_rst_c", 32'(cnt1), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("mid_rst_z2", 32'(zout1), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_z", 32'(zout1), 32'd0);
    checkOutput("post_rst_c", 32'(cnt1), 32'd0);
    runStream("post", 8'b0000_1011, 4, 8'b0000_0001);
    checkOutput("post_cnt", 32'(cnt1), 32'd1);

    // Non-overlapping: the second 1011 needs four fresh bits.
    resetBoth();
    overlap = 1'b0;
    runStream("nov_a", 8'b0101_1011, 7, 8'b0000_1000);
    checkOutput("nov_a_cnt", 32'(cnt1), 32'd1);
    resetBoth();
    runStream("nov_b", 8'b1011_1011, 8, 8'b0001_0001);
    checkOutput("nov_b_cnt", 32'(cnt1), 32'd2);

    // Load 1101 after a partial 1011, then feed 1101 with enable gaps.
    resetBoth();
    overlap = 1'b1;
    runStream("ld_pre", 8'b0000_0101, 3, 8'b0000_0000);
    pat_in1 = 4'b1101;
    pat_in2 = 2'b11;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("ld_z", 32'(zout1), 32'd0);
    checkOutput("ld_cnt", 32'(cnt1), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("gap_z1", 32'(zout1), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("gap_idle1", 32'(zout1), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("gap_z2", 32'(zout1), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("gap_idle2", 32'(zout1), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("gap_z3", 32'(zout1), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("gap_idle3", 32'(zout1), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("gap_z4", 32'(zout1), 32'd1);
    checkOutput("gap_cnt", 32'(cnt1), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("gap_after", 32'(zout1), 32'd0);
    checkOutput("gap_cnt_hold", 32'(cnt1), 32'd1);

    // Saturation: pattern 11 with a 2-bit counter on six 1s.
    resetBoth();
    overlap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("sat_z%0d", i + 1), 32'(zout2), (i == 0) ? 32'd0 : 32'd1);
      checkOutput($sformatf("sat_c%0d", i + 1), 32'(cnt2), (i >= 3) ? 32'd3 : 32'(i));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_idle_z", 32'(zout2), 32'd0);
    checkOutput("sat_idle_c", 32'(cnt2), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
